// File: rtl/alu_writeback.sv
// ALU writeback stage: buffers dual-result ALU pairs in a small FIFO and
// serialises them onto the register file's single write port (Y1, then optional Y2).
module alu_writeback #(
    parameter int DEPTH = 2,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [31:0]   in_y1_i,
    input  logic [31:0]   in_y2_i,
    input  logic [AW-1:0] in_rd1_i,
    input  logic [AW-1:0] in_rd2_i,
    input  logic          in_wr2_i,
    input  logic [1:0]    in_prec_i,
    output logic          wb_valid_o,
    input  logic          wb_grant_i,
    output logic [AW-1:0] wb_addr_o,
    output logic [31:0]   wb_data_o,
    output logic          busy_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        SEND_Y1 = 2'd1,
        SEND_Y2 = 2'd2
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;

    logic [31:0]     y1_mem  [DEPTH];
    logic [31:0]     y2_mem  [DEPTH];
    logic [AW-1:0]   rd1_mem [DEPTH];
    logic [AW-1:0]   rd2_mem [DEPTH];
    logic            two_mem [DEPTH];

    logic            push;
    logic            pop;
    logic            head_two;

    function automatic logic [31:0] mask_prec(input logic [31:0] v, input logic [1:0] prec);
        case (prec)
            2'b00:   mask_prec = {24'd0, v[7:0]};
            2'b01:   mask_prec = {16'd0, v[15:0]};
            default: mask_prec = v;
        endcase
    endfunction

    assign in_ready_o = (count_q != CW'(DEPTH));
    assign busy_o     = (count_q != '0);
    assign push       = in_valid_i && in_ready_o;
    assign head_two   = two_mem[rd_ptr_q];
    // An entry leaves the FIFO only on its last granted write.
    assign pop        = wb_grant_i && ((state_q == SEND_Y2) || (state_q == SEND_Y1 && !head_two));

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            y1_mem[wr_ptr_q]  <= mask_prec(in_y1_i, in_prec_i);
            y2_mem[wr_ptr_q]  <= mask_prec(in_y2_i, in_prec_i);
            rd1_mem[wr_ptr_q] <= in_rd1_i;
            rd2_mem[wr_ptr_q] <= in_rd2_i;
            two_mem[wr_ptr_q] <= in_wr2_i | (in_prec_i == 2'b11);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_q <= SEND_Y1;
                    end
                end
                SEND_Y1: begin
                    if (wb_grant_i) begin
                        if (head_two) begin
                            state_q <= SEND_Y2;
                        end else begin
                            state_q <= (count_d != '0) ? SEND_Y1 : EMPTY;
                        end
                    end
                end
                SEND_Y2: begin
                    if (wb_grant_i) begin
                        state_q <= (count_d != '0) ? SEND_Y1 : EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    always_comb begin
        wb_valid_o = 1'b0;
        wb_addr_o  = '0;
        wb_data_o  = '0;
        case (state_q)
            SEND_Y1: begin
                wb_valid_o = 1'b1;
                wb_addr_o  = rd1_mem[rd_ptr_q];
                wb_data_o  = y1_mem[rd_ptr_q];
            end
            SEND_Y2: begin
                wb_valid_o = 1'b1;
                wb_addr_o  = rd2_mem[rd_ptr_q];
                wb_data_o  = y2_mem[rd_ptr_q];
            end
            default: ;
        endcase
    end

endmodule
